// File: rtl/cdb_scheduler_if.sv
// Handshake and broadcast bundle between the execution units (master side)
// and the common-data-bus scheduler (slave side).
interface cdb_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
);
    logic              req_int, req_ld, req_mult, req_div;
    logic              div_busy;
    logic [DATA_W-1:0] int_res_data, ld_res_data, mult_res_data, div_res_data;
    logic [TAG_W-1:0]  int_res_tag, ld_res_tag, mult_res_tag, div_res_tag;
    logic              int_branch, int_branch_taken;
    logic              grant_int, grant_ld, grant_mult, grant_div;
    logic              cdb_valid;
    logic [DATA_W-1:0] cdb_data;
    logic [TAG_W-1:0]  cdb_tag;
    logic [1:0]        cdb_src;
    logic              cdb_branch, cdb_branch_taken;
    logic [15:0]       deny_cnt;

    modport master (
        output req_int, req_ld, req_mult, req_div, div_busy,
        output int_res_data, ld_res_data, mult_res_data, div_res_data,
        output int_res_tag, ld_res_tag, mult_res_tag, div_res_tag,
        output int_branch, int_branch_taken,
        input  grant_int, grant_ld, grant_mult, grant_div,
        input  cdb_valid, cdb_data, cdb_tag, cdb_src,
        input  cdb_branch, cdb_branch_taken, deny_cnt
    );

    modport slave (
        input  req_int, req_ld, req_mult, req_div, div_busy,
        input  int_res_data, ld_res_data, mult_res_data, div_res_data,
        input  int_res_tag, ld_res_tag, mult_res_tag, div_res_tag,
        input  int_branch, int_branch_taken,
        output grant_int, grant_ld, grant_mult, grant_div,
        output cdb_valid, cdb_data, cdb_tag, cdb_src,
        output cdb_branch, cdb_branch_taken, deny_cnt
    );
endinterface

// File: rtl/cdb_scheduler.sv
// CDB scheduler: books future bus cycles in a reservation table so that
// int/ld/mult/div results of differing latency never collide on the CDB.
module cdb_scheduler #(
    parameter int DATA_W          = 32,
    parameter int TAG_W           = 6,
    parameter int MULT_LAT        = 4,
    parameter int DIV_LAT         = 7,
    parameter int ARB_MODE        = 0,
    parameter int INT_BEFORE_LOAD = 1
) (
    input  logic          clk,
    input  logic          reset,
    cdb_scheduler_if.slave bus
);
    localparam logic [1:0] SRC_INT  = 2'd0;
    localparam logic [1:0] SRC_LD   = 2'd1;
    localparam logic [1:0] SRC_MULT = 2'd2;
    localparam logic [1:0] SRC_DIV  = 2'd3;

    // res_vld[k] set means the CDB is already owned k cycles from now
    logic [DIV_LAT:1]  res_vld;
    logic [1:0]        res_src [1:DIV_LAT];
    logic              lru;
    logic              grant_int, grant_ld, grant_mult, grant_div;
    logic              fav_int, int_ld_conflict, any_deny;
    logic              nxt_valid;
    logic [1:0]        nxt_src;
    logic [DATA_W-1:0] nxt_data;
    logic [TAG_W-1:0]  nxt_tag;
    logic              cdb_valid, cdb_branch, cdb_branch_taken;
    logic [DATA_W-1:0] cdb_data;
    logic [TAG_W-1:0]  cdb_tag;
    logic [1:0]        cdb_src;
    logic [15:0]       deny_cnt;

    always_comb begin
        grant_div  = reset && bus.req_div && !bus.div_busy && !res_vld[DIV_LAT];
        // equal latencies share one slot, which div claims first
        grant_mult = reset && bus.req_mult && !res_vld[MULT_LAT]
                     && !(grant_div && (MULT_LAT == DIV_LAT));
        fav_int    = (ARB_MODE == 0) ? (INT_BEFORE_LOAD != 0) : lru;
        grant_int  = reset && bus.req_int && !res_vld[1] && (!bus.req_ld || fav_int);
        grant_ld   = reset && bus.req_ld && !res_vld[1] && (!bus.req_int || !fav_int);
        int_ld_conflict = bus.req_int && bus.req_ld && (grant_int || grant_ld);
        any_deny   = (bus.req_int && !grant_int) || (bus.req_ld && !grant_ld)
                     || (bus.req_mult && !grant_mult) || (bus.req_div && !grant_div);
        nxt_valid  = res_vld[1] || grant_int || grant_ld;
        nxt_src    = res_vld[1] ? res_src[1] : (grant_int ? SRC_INT : SRC_LD);
        nxt_data   = bus.int_res_data;
        nxt_tag    = bus.int_res_tag;
        case (nxt_src)
            SRC_LD:   begin nxt_data = bus.ld_res_data;   nxt_tag = bus.ld_res_tag;   end
            SRC_MULT: begin nxt_data = bus.mult_res_data; nxt_tag = bus.mult_res_tag; end
            SRC_DIV:  begin nxt_data = bus.div_res_data;  nxt_tag = bus.div_res_tag;  end
            default:  begin nxt_data = bus.int_res_data;  nxt_tag = bus.int_res_tag;  end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            res_vld <= '0;
            for (int k = 1; k <= DIV_LAT; k++) res_src[k] <= SRC_INT;
            lru              <= (INT_BEFORE_LOAD != 0);
            cdb_valid        <= 1'b0;
            cdb_data         <= '0;
            cdb_tag          <= '0;
            cdb_src          <= SRC_INT;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
            deny_cnt         <= 16'd0;
        end else begin
            // table slides one step toward k=1 and picks up this cycle's long-latency grants
            for (int k = 1; k < DIV_LAT; k++) begin
                res_vld[k] <= res_vld[k+1] || (grant_mult && (MULT_LAT == k + 1))
                              || (grant_div && (DIV_LAT == k + 1));
                res_src[k] <= (grant_div && (DIV_LAT == k + 1))   ? SRC_DIV  :
                              (grant_mult && (MULT_LAT == k + 1)) ? SRC_MULT : res_src[k+1];
            end
            res_vld[DIV_LAT] <= 1'b0;
            res_src[DIV_LAT] <= SRC_INT;
            if (ARB_MODE != 0 && int_ld_conflict) lru <= grant_ld;
            cdb_valid        <= nxt_valid;
            cdb_branch       <= nxt_valid && (nxt_src == SRC_INT) && bus.int_branch;
            cdb_branch_taken <= nxt_valid && (nxt_src == SRC_INT) && bus.int_branch_taken;
            if (nxt_valid) begin
                cdb_src  <= nxt_src;
                cdb_data <= nxt_data;
                cdb_tag  <= nxt_tag;
            end
            if (any_deny && deny_cnt != 16'hFFFF) deny_cnt <= deny_cnt + 16'd1;
        end
    end

    assign bus.grant_int        = grant_int;
    assign bus.grant_ld         = grant_ld;
    assign bus.grant_mult       = grant_mult;
    assign bus.grant_div        = grant_div;
    assign bus.cdb_valid        = cdb_valid;
    assign bus.cdb_data         = cdb_data;
    assign bus.cdb_tag          = cdb_tag;
    assign bus.cdb_src          = cdb_src;
    assign bus.cdb_branch       = cdb_branch;
    assign bus.cdb_branch_taken = cdb_branch_taken;
    assign bus.deny_cnt         = deny_cnt;
endmodule

// File: tb/tb_cdb_scheduler.sv
// Bench for cdb_scheduler: instance 0 uses fixed int-first arbitration, instance 1 LRU;
// directed scenarios plus a random run against an absolute-time bus calendar model.
module tb_cdb_scheduler;
    localparam int DW   = 32;
    localparam int TW   = 6;
    localparam int ML   = 4;
    localparam int DL   = 7;
    localparam int TUPW = 1 + 2 + DW + TW + 2;
    localparam int NR   = 400;
    localparam int CAL  = NR + DL + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic r_int, r_ld, r_mult, r_div, busy, br, brt;
    logic [DW-1:0] d_int, d_ld, d_mult, d_div;
    logic [TW-1:0] t_int, t_ld, t_mult, t_div;

    logic [3:0]    o_gnt   [2];
    logic          o_valid [2];
    logic [1:0]    o_src   [2];
    logic [DW-1:0] o_data  [2];
    logic [TW-1:0] o_tag   [2];
    logic          o_br    [2];
    logic          o_brt   [2];
    logic [15:0]   o_deny  [2];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cdb_scheduler_if #(.DATA_W(DW), .TAG_W(TW)) bus ();
        assign bus.req_int = r_int;            assign bus.req_ld = r_ld;
        assign bus.req_mult = r_mult;          assign bus.req_div = r_div;
        assign bus.div_busy = busy;
        assign bus.int_res_data = d_int;       assign bus.ld_res_data = d_ld;
        assign bus.mult_res_data = d_mult;     assign bus.div_res_data = d_div;
        assign bus.int_res_tag = t_int;        assign bus.ld_res_tag = t_ld;
        assign bus.mult_res_tag = t_mult;      assign bus.div_res_tag = t_div;
        assign bus.int_branch = br;            assign bus.int_branch_taken = brt;
        cdb_scheduler #(.DATA_W(DW), .TAG_W(TW), .MULT_LAT(ML), .DIV_LAT(DL),
                        .ARB_MODE(g), .INT_BEFORE_LOAD(1)) dut (
            .clk(clk), .reset(reset), .bus(bus));
        assign o_gnt[g]   = {bus.grant_int, bus.grant_ld, bus.grant_mult, bus.grant_div};
        assign o_valid[g] = bus.cdb_valid;
        assign o_src[g]   = bus.cdb_src;
        assign o_data[g]  = bus.cdb_data;
        assign o_tag[g]   = bus.cdb_tag;
        assign o_br[g]    = bus.cdb_branch;
        assign o_brt[g]   = bus.cdb_branch_taken;
        assign o_deny[g]  = bus.deny_cnt;
    end

    function automatic logic [TUPW-1:0] cdb_of(int g);
        return {o_valid[g], o_src[g], o_data[g], o_tag[g], o_br[g], o_brt[g]};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        r_int = 0; r_ld = 0; r_mult = 0; r_div = 0; busy = 0; br = 0; brt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset = 1'b0;
        r_int = 1; r_ld = 1; r_mult = 1; r_div = 1; busy = 0; br = 1; brt = 1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            sample();
            for (int g = 0; g < 2; g++) begin
                n_checks++;
                if (o_gnt[g] !== 4'b0000) begin
                    n_fail++;
                    $display("[TB] FAIL reset_grants[%0d] got %b want 0000", g, o_gnt[g]);
                end
                n_checks++;
                if ({o_valid[g], o_deny[g], o_data[g]} !== '0) begin
                    n_fail++;
                    $display("[TB] FAIL reset_regs[%0d] got valid=%b deny=%0d data=%h want 0/0/0",
                             g, o_valid[g], o_deny[g], o_data[g]);
                end
            end
        end
        clear_inputs();
        reset = 1'b1;
    endtask

    task automatic test_fixed_arb();
        $display("[TB] test_fixed_arb");
        do_reset();
        next_cycle();
        r_int = 1; r_ld = 1; br = 1; brt = 0; d_int = 32'hA5A5_0001; t_int = 6'd11;
        sample();
        n_checks++;
        if (o_gnt[0] !== 4'b1000) begin
            n_fail++; $display("[TB] FAIL fixed_t0_grants got %b want 1000", o_gnt[0]);
        end
        next_cycle();
        r_int = 0; br = 0; d_ld = 32'h0BAD_0002; t_ld = 6'd22;
        sample();
        n_checks++;
        if (o_gnt[0] !== 4'b0100) begin
            n_fail++; $display("[TB] FAIL fixed_t1_grants got %b want 0100", o_gnt[0]);
        end
        n_checks++;
        if (cdb_of(0) !== {1'b1, 2'd0, 32'hA5A5_0001, 6'd11, 1'b1, 1'b0}) begin
            n_fail++; $display("[TB] FAIL fixed_t1_cdb got %h want int A5A50001 tag 11 br 1", cdb_of(0));
        end
        n_checks++;
        if (o_deny[0] !== 16'd1) begin
            n_fail++; $display("[TB] FAIL fixed_t1_deny got %0d want 1", o_deny[0]);
        end
        next_cycle();
        r_ld = 0;
        sample();
        n_checks++;
        if (cdb_of(0) !== {1'b1, 2'd1, 32'h0BAD_0002, 6'd22, 1'b0, 1'b0}) begin
            n_fail++; $display("[TB] FAIL fixed_t2_cdb got %h want ld 0BAD0002 tag 22", cdb_of(0));
        end
        next_cycle();
        sample();
        n_checks++;
        if (cdb_of(0) !== {1'b0, 2'd1, 32'h0BAD_0002, 6'd22, 1'b0, 1'b0}) begin
            n_fail++; $display("[TB] FAIL fixed_t3_hold got %h want invalid holding ld 0BAD0002", cdb_of(0));
        end
    endtask

    task automatic test_lru();
        logic [1:0]    prev_src;
        logic [DW-1:0] prev_data;
        logic [3:0]    want;
        $display("[TB] test_lru");
        do_reset();
        prev_src = 2'd0;
        prev_data = '0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            r_int = (i < 4); r_ld = (i < 4);
            d_int = 32'h100 + i; d_ld = 32'h200 + i;
            sample();
            want = (i >= 4) ? 4'b0000 : ((i % 2 == 0) ? 4'b1000 : 4'b0100);
            n_checks++;
            if (o_gnt[1] !== want) begin
                n_fail++; $display("[TB] FAIL lru_grants_t%0d got %b want %b", i, o_gnt[1], want);
            end
            if (i > 0) begin
                n_checks++;
                if ({o_valid[1], o_src[1], o_data[1]} !== {1'b1, prev_src, prev_data}) begin
                    n_fail++;
                    $display("[TB] FAIL lru_cdb_t%0d got v=%b src=%0d data=%h want 1/%0d/%h",
                             i, o_valid[1], o_src[1], o_data[1], prev_src, prev_data);
                end
            end
            prev_src  = (i % 2 == 0) ? 2'd0 : 2'd1;
            prev_data = (i % 2 == 0) ? d_int : d_ld;
        end
        clear_inputs();
    endtask

    task automatic test_mult_slot();
        $display("[TB] test_mult_slot");
        do_reset();
        next_cycle();
        r_mult = 1;
        sample();
        n_checks++;
        if (o_gnt[0] !== 4'b0010) begin
            n_fail++; $display("[TB] FAIL mult_t0_grants got %b want 0010", o_gnt[0]);
        end
        for (int i = 1; i < 3; i++) begin
            next_cycle();
            r_mult = 0;
            sample();
        end
        next_cycle();
        r_int = 1; br = 1; brt = 1; d_mult = 32'hCAFE_0033; t_mult = 6'd33;
        sample();
        n_checks++;
        if (o_gnt[0] !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL mult_t3_int_blocked got %b want 0000", o_gnt[0]);
        end
        next_cycle();
        d_int = 32'hBEEF_0044; t_int = 6'd44;
        sample();
        n_checks++;
        if (o_gnt[0] !== 4'b1000) begin
            n_fail++; $display("[TB] FAIL mult_t4_int_grant got %b want 1000", o_gnt[0]);
        end
        n_checks++;
        if (cdb_of(0) !== {1'b1, 2'd2, 32'hCAFE_0033, 6'd33, 1'b0, 1'b0}) begin
            n_fail++; $display("[TB] FAIL mult_t4_cdb got %h want mult CAFE0033 no branch", cdb_of(0));
        end
        next_cycle();
        clear_inputs();
        sample();
        n_checks++;
        if (cdb_of(0) !== {1'b1, 2'd0, 32'hBEEF_0044, 6'd44, 1'b1, 1'b1}) begin
            n_fail++; $display("[TB] FAIL mult_t5_cdb got %h want int BEEF0044 branch taken", cdb_of(0));
        end
        n_checks++;
        if (o_deny[0] !== 16'd1) begin
            n_fail++; $display("[TB] FAIL mult_t5_deny got %0d want 1", o_deny[0]);
        end
    endtask

    task automatic test_div_slot();
        $display("[TB] test_div_slot");
        do_reset();
        next_cycle();
        r_div = 1; busy = 1;
        sample();
        n_checks++;
        if (o_gnt[0] !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL div_busy_grants got %b want 0000", o_gnt[0]);
        end
        next_cycle();
        busy = 0;
        sample();
        n_checks++;
        if (o_gnt[0] !== 4'b0001) begin
            n_fail++; $display("[TB] FAIL div_t0_grants got %b want 0001", o_gnt[0]);
        end
        for (int t = 1; t <= 8; t++) begin
            next_cycle();
            r_div  = 0;
            r_mult = (t == 3 || t == 4);
            if (t == 6) begin d_div = 32'hD1D1_0055; t_div = 6'd55; end
            if (t == 7) begin d_mult = 32'h3333_0007; t_mult = 6'd7; end
            sample();
            if (t == 3 || t == 4) begin
                n_checks++;
                if (o_gnt[0] !== ((t == 3) ? 4'b0000 : 4'b0010)) begin
                    n_fail++; $display("[TB] FAIL div_t%0d_mult_grant got %b", t, o_gnt[0]);
                end
            end
            if (t == 6) begin
                n_checks++;
                if (o_valid[0] !== 1'b0) begin
                    n_fail++; $display("[TB] FAIL div_t6_idle got valid %b want 0", o_valid[0]);
                end
            end
            if (t == 7) begin
                n_checks++;
                if (cdb_of(0) !== {1'b1, 2'd3, 32'hD1D1_0055, 6'd55, 1'b0, 1'b0}) begin
                    n_fail++; $display("[TB] FAIL div_t7_cdb got %h want div D1D10055", cdb_of(0));
                end
            end
            if (t == 8) begin
                n_checks++;
                if (cdb_of(0) !== {1'b1, 2'd2, 32'h3333_0007, 6'd7, 1'b0, 1'b0}) begin
                    n_fail++; $display("[TB] FAIL div_t8_cdb got %h want mult 33330007", cdb_of(0));
                end
                n_checks++;
                if (o_deny[0] !== 16'd2) begin
                    n_fail++; $display("[TB] FAIL div_t8_deny got %0d want 2", o_deny[0]);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        $display("[TB] test_reset_mid");
        do_reset();
        next_cycle();
        r_mult = 1;
        sample();
        n_checks++;
        if (o_gnt[0] !== 4'b0010) begin
            n_fail++; $display("[TB] FAIL rmid_t0_grants got %b want 0010", o_gnt[0]);
        end
        for (int t = 1; t <= 6; t++) begin
            next_cycle();
            r_mult = 0;
            reset  = (t == 2) ? 1'b0 : 1'b1;
            sample();
            for (int g = 0; g < 2; g++) begin
                n_checks++;
                if (o_valid[g] !== 1'b0) begin
                    n_fail++; $display("[TB] FAIL rmid_t%0d_valid[%0d] got %b want 0", t, g, o_valid[g]);
                end
            end
        end
        n_checks++;
        if (o_deny[0] !== 16'd0) begin
            n_fail++; $display("[TB] FAIL rmid_deny got %0d want 0", o_deny[0]);
        end
    endtask

    // Calendar of CDB ownership indexed by absolute cycle number
    bit         cal_v [2][CAL];
    logic [1:0] cal_s [2][CAL];

    task automatic test_random();
        logic [TUPW-1:0] exp_t [2];
        int              exp_deny [2];
        bit              lru_m [2];
        bit              gi, gl, gm, gd, fav, free1;
        logic [1:0]      s;
        $display("[TB] test_random");
        do_reset();
        for (int g = 0; g < 2; g++) begin
            exp_t[g] = '0; exp_deny[g] = 0; lru_m[g] = 1'b1;
            for (int c = 0; c < CAL; c++) begin cal_v[g][c] = 1'b0; cal_s[g][c] = 2'd0; end
        end
        for (int c = 0; c < NR; c++) begin
            next_cycle();
            r_int  = ($urandom_range(0, 99) < 50);
            r_ld   = ($urandom_range(0, 99) < 50);
            r_mult = ($urandom_range(0, 99) < 30);
            r_div  = ($urandom_range(0, 99) < 25);
            busy   = ($urandom_range(0, 99) < 30);
            br     = ($urandom_range(0, 1) == 1);
            brt    = ($urandom_range(0, 1) == 1);
            d_int = $urandom(); d_ld = $urandom(); d_mult = $urandom(); d_div = $urandom();
            t_int = 6'($urandom_range(0, 63)); t_ld  = 6'($urandom_range(0, 63));
            t_mult = 6'($urandom_range(0, 63)); t_div = 6'($urandom_range(0, 63));
            sample();
            for (int g = 0; g < 2; g++) begin
                gd = r_div && !busy && !cal_v[g][c+DL];
                if (gd) begin cal_v[g][c+DL] = 1'b1; cal_s[g][c+DL] = 2'd3; end
                gm = r_mult && !cal_v[g][c+ML];
                if (gm) begin cal_v[g][c+ML] = 1'b1; cal_s[g][c+ML] = 2'd2; end
                free1 = !cal_v[g][c+1];
                fav = (g == 0) ? 1'b1 : lru_m[g];
                gi = r_int && free1 && (!r_ld || fav);
                gl = r_ld && free1 && (!r_int || !fav);
                if (gi) begin cal_v[g][c+1] = 1'b1; cal_s[g][c+1] = 2'd0; end
                if (gl) begin cal_v[g][c+1] = 1'b1; cal_s[g][c+1] = 2'd1; end
                if (g == 1 && r_int && r_ld && (gi || gl)) lru_m[g] = gl;
                n_checks++;
                if (o_gnt[g] !== {gi, gl, gm, gd}) begin
                    n_fail++; $display("[TB] FAIL rand_grants[%0d] cyc %0d got %b want %b",
                                       g, c, o_gnt[g], {gi, gl, gm, gd});
                end
                n_checks++;
                if (cdb_of(g) !== exp_t[g]) begin
                    n_fail++; $display("[TB] FAIL rand_cdb[%0d] cyc %0d got %h want %h",
                                       g, c, cdb_of(g), exp_t[g]);
                end
                n_checks++;
                if (o_deny[g] !== 16'(exp_deny[g])) begin
                    n_fail++; $display("[TB] FAIL rand_deny[%0d] cyc %0d got %0d want %0d",
                                       g, c, o_deny[g], exp_deny[g]);
                end
                if (((r_int && !gi) || (r_ld && !gl) || (r_mult && !gm) || (r_div && !gd))
                    && exp_deny[g] < 65535) exp_deny[g]++;
                if (cal_v[g][c+1]) begin
                    s = cal_s[g][c+1];
                    case (s)
                        2'd0:    exp_t[g] = {1'b1, s, d_int,  t_int,  br, brt};
                        2'd1:    exp_t[g] = {1'b1, s, d_ld,   t_ld,   2'b00};
                        2'd2:    exp_t[g] = {1'b1, s, d_mult, t_mult, 2'b00};
                        default: exp_t[g] = {1'b1, s, d_div,  t_div,  2'b00};
                    endcase
                end else begin
                    exp_t[g] = {1'b0, exp_t[g][TUPW-2:2], 2'b00};
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        d_int = '0; d_ld = '0; d_mult = '0; d_div = '0;
        t_int = '0; t_ld = '0; t_mult = '0; t_div = '0;
        test_reset();
        test_fixed_arb();
        test_lru();
        test_mult_slot();
        test_div_slot();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_scheduler.md
CDB_SCHEDULER -- requirements
Module: cdb_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W 32 result width; TAG_W 6 rename-tag width; MULT_LAT 4 multiplier grant-to-CDB cycles; DIV_LAT 7 divider grant-to-CDB cycles; ARB_MODE 0 int/load arbitration (0 fixed, 1 LRU); INT_BEFORE_LOAD 1 fixed-mode winner / LRU initial favourite.
REQ-002 Legal parameter range SHALL be 2 <= MULT_LAT <= DIV_LAT <= 16.
REQ-003 Ports SHALL be (name direction width meaning):
clk  in  1  sole clock, rising edge
reset  in  1  synchronous, active-low reset
req_int, req_ld, req_mult, req_div  in  1 each  unit has an instruction ready
div_busy  in  1  divider cannot accept
int_res_data, ld_res_data, mult_res_data, div_res_data  in  DATA_W each  unit result
int_res_tag, ld_res_tag, mult_res_tag, div_res_tag  in  TAG_W each  unit result tag
int_branch, int_branch_taken  in  1 each  int result is a branch / taken
grant_int, grant_ld, grant_mult, grant_div  out  1 each  issue pulse
cdb_valid  out  1  CDB broadcast valid
cdb_data  out  DATA_W  broadcast result
cdb_tag  out  TAG_W  broadcast tag
cdb_src  out  2  source: 0 int, 1 ld, 2 mult, 3 div
cdb_branch, cdb_branch_taken  out  1 each  branch info, int source only
deny_cnt  out  16  saturating count of cycles with at least one denied request

Function
REQ-004 Latency L SHALL be 1 for int and ld, MULT_LAT for mult, DIV_LAT for div: grant at cycle t gives cdb_valid=1 at t+L.
REQ-005 Unit SHALL drive result data/tag in cycle t+L-1; scheduler registers it onto CDB outputs at edge t+L.
REQ-006 Reservation table res[1..DIV_LAT] SHALL track CDB occupancy k cycles ahead with 2-bit source id per entry; each cycle shifts by one toward k=1.
REQ-007 A request with latency L SHALL be grantable only if res[L] is free after current-cycle grants of higher priority.
REQ-008 Slot priority SHALL be div > mult > int/ld; with MULT_LAT==DIV_LAT, div wins and mult is denied.
REQ-009 grant_div SHALL additionally require div_busy=0.
REQ-010 int vs ld, ARB_MODE=0: INT_BEFORE_LOAD=1 grants int, else ld; loser denied that cycle.
REQ-011 int vs ld, ARB_MODE=1: grant the side favoured by an lru bit; after each int/ld conflict the lru bit flips to the loser; non-conflict grants do not change it.
REQ-012 Grants SHALL be combinational from current inputs and registered state, one cycle wide, asserted only when the request is high.
REQ-013 At most one source SHALL own any CDB cycle; cdb_valid SHALL never drop a reserved broadcast.
REQ-014 When cdb_valid=0, cdb_data, cdb_tag and cdb_src SHALL hold their last values; cdb_branch and cdb_branch_taken SHALL be 0.
REQ-015 cdb_branch and cdb_branch_taken SHALL copy int_branch and int_branch_taken only for int-source broadcasts.
REQ-016 deny_cnt SHALL increment once per cycle in which any req_* is high and its grant low, and saturate at 0xFFFF.

Reset
REQ-017 With reset=0 at a clock edge, res, source ids, cdb_valid, cdb_data, cdb_tag, cdb_src, cdb_branch, cdb_branch_taken and deny_cnt SHALL clear to 0, and lru SHALL load INT_BEFORE_LOAD.
REQ-018 While reset=0, all grant outputs SHALL be 0.
REQ-019 Reset mid-operation SHALL discard pending reservations; no cdb_valid from pre-reset grants.

Verification (MULT_LAT=4, DIV_LAT=7)
REQ-020 reset=0 for 2 cycles with all req_* high -> all grants 0; cdb_valid=0; deny_cnt=0; cdb_data=0.
REQ-021 ARB_MODE=0, INT_BEFORE_LOAD=1, req_int=req_ld=1 at t0 -> grant_int=1, grant_ld=0, deny_cnt=1; t1 cdb_valid=1, cdb_src=0, grant_ld=1; t2 cdb_src=1.
REQ-022 ARB_MODE=1, req_int=req_ld=1 for 4 cycles -> grants int, ld, int, ld; cdb_src sequence 0,1,0,1 from t1.
REQ-023 grant_mult at t0, req_int at t3 -> grant_int=0 at t3, 1 at t4; mult on CDB at t4 (cdb_src=2), int at t5 (cdb_src=0).
REQ-024 req_div with div_busy=1 -> no grant; div_busy=0 at t0 -> grant_div; req_mult at t3 denied; granted t4; CDB div t7, mult t8.
REQ-025 grant_mult at t0; reset=0 at t2 for one cycle -> cdb_valid stays 0 through t6; deny_cnt=0.
